// File: rtl/cv32e40x_bch_resolver.sv
// Branch resolver: 2-bit BHT predictor for the conditional branch in ID,
// an in-flight queue of issued branches, and a registered mispredict
// redirect to IF once EX has resolved the branch.
module cv32e40x_bch_resolver #(
  parameter int unsigned BHT_ENTRIES  = 16,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_bch_fire_i,
  input  logic [31:0] pc_id_i,
  input  logic [31:0] bch_target_i,
  input  logic        id_compressed_i,
  output logic        bch_prediction_id_o,
  output logic        id_ready_o,
  input  logic        ex_bch_resolve_i,
  input  logic        ex_bch_taken_i,
  input  logic        flush_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] mispredict_cnt_o,
  output logic        protocol_err_o
);

  localparam int unsigned IW = $clog2(BHT_ENTRIES);
  localparam int unsigned PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  typedef struct packed {
    logic [31:0]   target;
    logic [31:0]   fallthrough;
    logic          pred;
    logic [IW-1:0] idx;
  } entry_t;

  logic [1:0]    bht_q   [BHT_ENTRIES];
  entry_t        queue_q [MAX_INFLIGHT];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] id_idx;
  logic          full, empty;
  logic          push, pop, clear, push_eff, mispredict;
  entry_t        head, new_entry;

  // Pointers wrap at the queue depth, which need not fill the pointer width.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_INFLIGHT - 1)) return '0;
    else                            return p + PW'(1);
  endfunction

  // Prediction lookup, queue handshake and mispredict detection.
  always_comb begin
    id_idx              = pc_id_i[IW+1:2];
    bch_prediction_id_o = bht_q[id_idx][1];
    full                = (cnt_q == CW'(MAX_INFLIGHT));
    empty               = (cnt_q == '0);
    id_ready_o          = !full || ex_bch_resolve_i;
    push                = id_bch_fire_i && id_ready_o;
    pop                 = ex_bch_resolve_i && !empty && !flush_i;
    head                = queue_q[rd_ptr_q];
    mispredict          = pop && (head.pred != ex_bch_taken_i);
    // A mispredict makes every younger branch wrong-path, including one entering now.
    clear               = flush_i || mispredict;
    push_eff            = push && !clear;
    new_entry.target      = bch_target_i;
    new_entry.fallthrough = pc_id_i + (id_compressed_i ? 32'd2 : 32'd4);
    new_entry.pred        = bch_prediction_id_o;
    new_entry.idx         = id_idx;
  end

  // Next occupancy.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else begin
      if (push_eff) cnt_d = cnt_d + CW'(1);
      if (pop)      cnt_d = cnt_d - CW'(1);
    end
  end

  // In-flight queue storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(MAX_INFLIGHT); i++) queue_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (clear) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (push_eff) begin
          queue_q[wr_ptr_q] <= new_entry;
          wr_ptr_q          <= ptr_inc(wr_ptr_q);
        end
      end
    end
  end

  // BHT training on every resolved (non-flushed) branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= 2'b01;
    end else if (pop) begin
      if (ex_bch_taken_i && bht_q[head.idx] != 2'b11)
        bht_q[head.idx] <= bht_q[head.idx] + 2'b01;
      else if (!ex_bch_taken_i && bht_q[head.idx] != 2'b00)
        bht_q[head.idx] <= bht_q[head.idx] - 2'b01;
    end
  end

  // Registered redirect, mispredict count and protocol error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_o       <= 1'b0;
      redirect_pc_o    <= '0;
      mispredict_cnt_o <= '0;
      protocol_err_o   <= 1'b0;
    end else begin
      redirect_o     <= mispredict;
      protocol_err_o <= (id_bch_fire_i && !id_ready_o) || (ex_bch_resolve_i && empty);
      if (mispredict) begin
        redirect_pc_o <= ex_bch_taken_i ? head.target : head.fallthrough;
        if (mispredict_cnt_o != 32'hFFFF_FFFF)
          mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_bch_resolver.sv
// Bench for cv32e40x_bch_resolver: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_cv32e40x_bch_resolver;

  localparam int BHT_ENTRIES  = 16;
  localparam int MAX_INFLIGHT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_bch_fire_i, id_compressed_i, ex_bch_resolve_i, ex_bch_taken_i, flush_i;
  logic [31:0] pc_id_i, bch_target_i;
  logic        bch_prediction_id_o, id_ready_o, redirect_o, protocol_err_o;
  logic [31:0] redirect_pc_o, mispredict_cnt_o;

  cv32e40x_bch_resolver #(.BHT_ENTRIES(BHT_ENTRIES), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_bch_fire_i(id_bch_fire_i), .pc_id_i(pc_id_i), .bch_target_i(bch_target_i),
    .id_compressed_i(id_compressed_i), .bch_prediction_id_o(bch_prediction_id_o),
    .id_ready_o(id_ready_o), .ex_bch_resolve_i(ex_bch_resolve_i),
    .ex_bch_taken_i(ex_bch_taken_i), .flush_i(flush_i), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .mispredict_cnt_o(mispredict_cnt_o),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] ft;
    bit          pred;
    int          idx;
  } ent_t;

  ent_t        mq[$];
  int          m_bht[BHT_ENTRIES];
  bit          m_redirect, m_perr;
  logic [31:0] m_rpc, m_cnt;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_redirect = 0; m_perr = 0; m_rpc = 0; m_cnt = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".redirect"}, {31'd0, redirect_o}, {31'd0, m_redirect});
    chk({tag, ".redirect_pc"}, redirect_pc_o, m_rpc);
    chk({tag, ".mis_cnt"}, mispredict_cnt_o, m_cnt);
    chk({tag, ".perr"}, {31'd0, protocol_err_o}, {31'd0, m_perr});
  endtask

  // One clock: drive inputs, check ID-side outputs, advance model, check registered outputs.
  task automatic step(input bit fire, input logic [31:0] pc, input logic [31:0] tgt,
                      input bit comp, input bit res, input bit taken, input bit flush,
                      input string tag);
    int   idx;
    bit   e_pred, e_ready, push, mis;
    ent_t e;
    id_bch_fire_i = fire; pc_id_i = pc; bch_target_i = tgt; id_compressed_i = comp;
    ex_bch_resolve_i = res; ex_bch_taken_i = taken; flush_i = flush;
    #1;
    idx     = int'((pc >> 2) % BHT_ENTRIES);
    e_pred  = (m_bht[idx] >= 2);
    e_ready = (mq.size() < MAX_INFLIGHT) || res;
    chk({tag, ".pred"}, {31'd0, bch_prediction_id_o}, {31'd0, e_pred});
    chk({tag, ".ready"}, {31'd0, id_ready_o}, {31'd0, e_ready});
    push   = fire && e_ready;
    m_perr = (fire && !e_ready) || (res && mq.size() == 0);
    mis    = 0;
    if (flush) begin
      mq.delete();
      push = 0;
    end else if (res && mq.size() > 0) begin
      e = mq.pop_front();
      if (taken) m_bht[e.idx] = (m_bht[e.idx] == 3) ? 3 : m_bht[e.idx] + 1;
      else       m_bht[e.idx] = (m_bht[e.idx] == 0) ? 0 : m_bht[e.idx] - 1;
      if (e.pred != taken) begin
        mis   = 1;
        m_rpc = taken ? e.tgt : e.ft;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        mq.delete();
        push = 0;
      end
    end
    if (push) begin
      e.tgt = tgt; e.ft = pc + (comp ? 32'd2 : 32'd4); e.pred = e_pred; e.idx = idx;
      mq.push_back(e);
    end
    m_redirect = mis;
    @(posedge clk);
    #1;
    chk_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk_regs({tag, ".in_rst"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    id_bch_fire_i = 0; pc_id_i = 0; bch_target_i = 0; id_compressed_i = 0;
    ex_bch_resolve_i = 0; ex_bch_taken_i = 0; flush_i = 0; rst_n = 1'b1;
    #1;
    do_reset("rst");

    // 1: first taken resolve mispredicts against the weak not-taken reset state
    step(1, 32'h100, 32'h80, 0, 0, 0, 0, "t1.fire");
    step(0, 32'h100, 32'h80, 0, 1, 1, 0, "t1.res");
    chk("t1.redirect_pc_const", redirect_pc_o, 32'h80);
    chk("t1.cnt_const", mispredict_cnt_o, 32'd1);

    // 2: train to strongly taken, then a not-taken resolve goes to fallthrough
    repeat (3) begin
      step(1, 32'h100, 32'h80, 0, 0, 0, 0, "t2.fire");
      step(0, 32'h100, 32'h80, 0, 1, 1, 0, "t2.res");
    end
    chk("t2.cnt_const", mispredict_cnt_o, 32'd1);
    step(1, 32'h100, 32'h80, 0, 0, 0, 0, "t2.fire_nt");
    step(0, 32'h100, 32'h80, 0, 1, 0, 0, "t2.res_nt");
    chk("t2.redirect_pc_const", redirect_pc_o, 32'h104);

    // 3: compressed branch at the top of the address space wraps its fallthrough
    step(1, 32'hFFFF_FFFE, 32'h40, 1, 0, 0, 0, "t3.fire0");
    step(0, 32'h0, 32'h0, 0, 1, 0, 0, "t3.res0");
    repeat (2) begin
      step(1, 32'hFFFF_FFFE, 32'h40, 1, 0, 0, 0, "t3.train_f");
      step(0, 32'h0, 32'h0, 0, 1, 1, 0, "t3.train_r");
    end
    step(1, 32'hFFFF_FFFE, 32'h40, 1, 0, 0, 0, "t3.fire1");
    step(0, 32'h0, 32'h0, 0, 1, 0, 0, "t3.res1");
    chk("t3.wrap_const", redirect_pc_o, 32'h0);

    // 4: fill the queue, overflow attempt, then fire+resolve while full
    step(1, 32'h208, 32'h300, 0, 0, 0, 0, "t4.f1");
    step(1, 32'h208, 32'h300, 0, 0, 0, 0, "t4.f2");
    step(1, 32'h208, 32'h300, 0, 0, 0, 0, "t4.f3_over");
    step(1, 32'h208, 32'h300, 0, 1, 0, 0, "t4.fire_res");
    step(0, 32'h208, 32'h300, 0, 0, 0, 0, "t4.idle");
    step(0, 32'h208, 32'h300, 0, 1, 0, 0, "t4.drain1");
    step(0, 32'h208, 32'h300, 0, 1, 0, 0, "t4.drain2");

    // 5: flush beats a mispredicting resolve; then resolve on empty queue
    step(1, 32'h20C, 32'h500, 0, 0, 0, 0, "t5.fire");
    step(1, 32'h20C, 32'h500, 0, 1, 1, 1, "t5.flush_res");
    step(0, 32'h20C, 32'h500, 0, 1, 1, 0, "t5.res_empty");

    // 6: reset between fire and resolve
    step(1, 32'h100, 32'h80, 0, 0, 0, 0, "t6.fire");
    do_reset("t6");
    step(0, 32'h100, 32'h80, 0, 1, 1, 0, "t6.res_after_rst");

    // Random traffic with aliasing PCs and occasional flush/reset.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = {$urandom_range(0, 255), 2'b00} + ((($urandom % 4) == 0) ? 32'hFFFF_FC00 : 32'h0);
      if ($urandom % 3 == 0) pc[1] = 1'b1;
      step($urandom % 2 == 0, pc, $urandom & 32'hFFFF_FFFE, $urandom % 2 == 0,
           $urandom % 2 == 0, $urandom % 2 == 0, $urandom % 16 == 0, "rnd");
      if ($urandom % 400 == 0) do_reset("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
